norm_vec_serializer: RTL
========================

Name: norm_vec_serializer

Overview:
- Sits directly downstream of the vector-normalisation pipeline (square → adder tree → sqrt → four dividers).
- Captures the four quotient lanes (A,B,C,D), each DATAWIDTH+1 bits, when they arrive together, and buffers whole vectors in a small FIFO.
- Emits each buffered vector as four ready/valid beats on one narrow bus.
- Absorbs the lack of backpressure in the normalisation pipeline: it counts dropped vectors and flags lane misalignment.

Parameters:
- DATAWIDTH, 16, input sample width; each quotient lane is DATAWIDTH+1 bits.
- FIFO_DEPTH, 4, vectors buffered; must be a power of two and ≥2.
- INSTANCE_ID, 0, instance tag, consistent with the other pipeline blocks; no functional effect.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_valid_A / i_valid_B / i_valid_C / i_valid_D  in  1 each  per-lane valid from the dividers
- i_A / i_B / i_C / i_D  in  DATAWIDTH+1 each  quotient lanes
- i_ready  in  1  downstream consumer ready
- o_valid  out  1  beat valid
- o_data  out  DATAWIDTH+1  current component
- o_idx  out  2  component index: 0=A, 1=B, 2=C, 3=D
- o_last  out  1  high when o_idx==3
- o_almost_full  out  1  FIFO occupancy ≥ FIFO_DEPTH-1
- o_drop_cnt  out  8  vectors dropped because the FIFO was full; saturates at 255
- o_misalign  out  1  sticky: lane valids disagreed in some cycle

Behaviour:
- Reset (synchronous, active-high), all held at 0 on the cycle after rst is sampled high:
  - o_valid, o_data, o_idx, o_last, o_almost_full, o_drop_cnt, o_misalign
  - FIFO count and pointers, beat counter; FSM returns to S_IDLE.
  - Reset mid-operation discards buffered vectors and any partial beat sequence.
- Push condition:
  - all_v = AND of the four lane valids.
  - Push when all_v && (count < FIFO_DEPTH || pop_this_cycle).
  - A simultaneous push and pop when full is allowed; count is unchanged.
- Drop: all_v while full and no pop this cycle → vector discarded; o_drop_cnt += 1, saturating at 255.
- Misalignment: any lane valid high but not all four → o_misalign set (cleared only by rst); that cycle's data is not pushed.
- FSM, 2 states:
  - S_IDLE: o_valid=0. When count>0 → go to S_SEND with beat=0.
  - S_SEND: o_valid=1, o_data = head.lane[beat], o_idx=beat.
    - On o_valid && i_ready: beat += 1.
    - On the beat==3 handshake: pop the head and reset beat to 0. Stay in S_SEND if count after the pop > 0, else go to S_IDLE.
- Latency: a vector pushed at edge N gives o_valid=1 with beat 0 from cycle N+1 when the FIFO was empty. Back-to-back vectors stream with no bubble.
- Output stability: o_data, o_idx and o_last hold stable while o_valid && !i_ready.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
- Data is passed through unmodified; no arithmetic on lanes.

Decomposition:
- Shared package norm_pkg:
  - localparam NUM_COMP=4
  - typedef comp_idx_t (2 bits)
  - typedef struct norm_vec_t, holding four DATAWIDTH+1 lanes, packed A..D
  - enum ser_state_t {S_IDLE, S_SEND}
- One sub-module, norm_vec_fifo: a synchronous FIFO of norm_vec_t with push, pop, full, empty, count and registered storage. The head is read combinationally.

Test Plan:
- Single vector A=0x0100, B=0x0080, C=0x0040, D=0x0020 with i_ready=1 → beats idx 0..3 on cycles N+1..N+4 carrying exactly those values; o_last only on the 4th beat; then S_IDLE.
- i_ready=0 for 3 cycles after o_valid rises → o_data=0x0100, idx=0 held stable; resuming i_ready gives the full sequence in order.
- 6 consecutive vectors, all valid, with i_ready=0 and FIFO_DEPTH=4 → 4 buffered, o_drop_cnt=2, o_almost_full=1 once count≥3; draining delivers vectors 1..4 in order.
- Full FIFO with the last beat handshaking in the same cycle as a new all-valid vector → vector accepted, o_drop_cnt unchanged, count stays 4.
- i_valid_A=1 only for one cycle → o_misalign=1 and stays 1; no push; the next aligned vector is still processed normally.
- rst asserted during the beat idx=2 → next cycle o_valid=0, count=0, o_drop_cnt=0, o_misalign=0; a post-reset vector starts at idx 0.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types for the vector-normalisation output stage.
package norm_pkg;

  localparam int unsigned NUM_COMP = 4;
  localparam int unsigned NORM_DW  = 16;

  typedef logic [1:0] comp_idx_t;

  // Default-width vector; instances with another DATAWIDTH pass their own type.
  typedef struct packed {
    logic [NORM_DW:0] a;
    logic [NORM_DW:0] b;
    logic [NORM_DW:0] c;
    logic [NORM_DW:0] d;
  } norm_vec_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_t;

endpackage

// File: rtl/norm_vec_fifo.sv
// Synchronous FIFO of whole normalised vectors; head is read combinationally.
module norm_vec_fifo
  import norm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         vec_t = norm_vec_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  vec_t                     wdata_i,
  output vec_t                     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  vec_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/norm_vec_serializer.sv
// Buffers four-lane quotient vectors and emits them as four ready/valid beats.
module norm_vec_serializer
  import norm_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned INSTANCE_ID = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid_A,
  input  logic               i_valid_B,
  input  logic               i_valid_C,
  input  logic               i_valid_D,
  input  logic [DATAWIDTH:0] i_A,
  input  logic [DATAWIDTH:0] i_B,
  input  logic [DATAWIDTH:0] i_C,
  input  logic [DATAWIDTH:0] i_D,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [DATAWIDTH:0] o_data,
  output logic [1:0]         o_idx,
  output logic               o_last,
  output logic               o_almost_full,
  output logic [7:0]         o_drop_cnt,
  output logic               o_misalign
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATAWIDTH:0] a;
    logic [DATAWIDTH:0] b;
    logic [DATAWIDTH:0] c;
    logic [DATAWIDTH:0] d;
  } vec_t;

  ser_state_t         state_q;
  comp_idx_t          beat_q;
  logic               valid_q;
  logic [7:0]         drop_q;
  logic               misalign_q;

  vec_t               in_vec, head;
  logic               all_v, any_v, pop, push, drop, full, empty;
  logic [CW-1:0]      count;
  logic [DATAWIDTH:0] lane;
  logic               instance_unused;

  assign instance_unused = (INSTANCE_ID != 0);

  assign all_v  = i_valid_A & i_valid_B & i_valid_C & i_valid_D;
  assign any_v  = i_valid_A | i_valid_B | i_valid_C | i_valid_D;
  assign in_vec = '{a: i_A, b: i_B, c: i_C, d: i_D};
  assign pop    = (state_q == S_SEND) && i_ready && (beat_q == 2'd3);
  assign push   = all_v && (!full || pop);
  assign drop   = all_v && full && !pop;

  norm_vec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .vec_t (vec_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_vec),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    lane = head.a;
    case (beat_q)
      2'd0: lane = head.a;
      2'd1: lane = head.b;
      2'd2: lane = head.c;
      2'd3: lane = head.d;
      default: lane = head.a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      valid_q    <= 1'b0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (any_v && !all_v) misalign_q <= 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          beat_q <= '0;
          if (!empty) begin
            state_q <= S_SEND;
            valid_q <= 1'b1;
          end
        end
        S_SEND: begin
          if (i_ready) begin
            if (beat_q == 2'd3) begin
              beat_q <= '0;
              // Keep streaming if another vector remains after this pop.
              if (count > CW'(1) || push) begin
                state_q <= S_SEND;
                valid_q <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          beat_q  <= '0;
        end
      endcase
    end
  end

  // Head storage is not reset, so the data bus is gated to read zero when idle.
  assign o_valid       = valid_q;
  assign o_data        = valid_q ? lane : '0;
  assign o_idx         = beat_q;
  assign o_last        = valid_q && (beat_q == 2'd3);
  assign o_almost_full = (count >= CW'(FIFO_DEPTH - 1));
  assign o_drop_cnt    = drop_q;
  assign o_misalign    = misalign_q;

endmodule
